// File: rtl/nibble_serial_addsub_pkg.sv
// Shared ALU definitions: FSM state encoding, slice width and flag bit order.
package nibble_serial_addsub_pkg;

    // Control FSM states of the serial add/subtract unit
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of one processed slice
    localparam int NIB_W = 4;

    // Bit order of the ALU flag register: {overflow, carry, zero}
    localparam int FLAG_W     = 3;
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;

endpackage

// File: rtl/nibble_serial_addsub_cla4.sv
// 4-bit carry-lookahead nibble adder, purely combinational.
module nibble_serial_addsub_cla4
    import nibble_serial_addsub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    // Generate/propagate terms and fully expanded lookahead carries
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[NIB_W-1:0];
        cout = c[NIB_W];
    end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit add/subtract: one nibble per cycle through a single
// CLA nibble adder, carry chained through a register. Handshake: start is
// taken only when not busy (IDLE or DONE); busy is high for the NIBBLES RUN
// cycles; done pulses for one cycle with result and flags already valid.
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16  // multiple of 4, at least 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;      // holds ~b for subtraction
    logic              c_q, c_d;      // chained carry; starts as the sub flag
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [FLAG_W-1:0] flags_q, flags_d;

    logic [NIB_W-1:0]  nib_a;
    logic [NIB_W-1:0]  nib_b;
    logic [NIB_W-1:0]  nib_sum;
    logic              nib_cout;

    // Current slice selection feeding the shared nibble adder
    always_comb begin
        nib_a = a_q[NIB_W*idx_q +: NIB_W];
        nib_b = b_q[NIB_W*idx_q +: NIB_W];
    end

    nibble_serial_addsub_cla4 u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (c_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Next-state, datapath and flag computation
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new start just like IDLE, so back-to-back
                // operations need no bubble cycle.
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub;        // +1 of the two's-complement negate
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d[NIB_W*idx_q +: NIB_W] = nib_sum;
                c_d   = nib_cout;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // Publish on the edge that enters DONE; overflow uses the
                    // already-inverted b so it covers add and subtract alike.
                    state_d             = ST_DONE;
                    result_d            = acc_d;
                    flags_d[FLAG_CARRY] = nib_cout;
                    flags_d[FLAG_OVF]   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                                       && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                    flags_d[FLAG_ZERO]  = (acc_d == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Outputs decoded only from registers
    always_comb begin
        busy     = (state_q == ST_RUN);
        done     = (state_q == ST_DONE);
        result   = result_q;
        carry    = flags_q[FLAG_CARRY];
        overflow = flags_q[FLAG_OVF];
        zero     = flags_q[FLAG_ZERO];
    end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub (WIDTH=16): vector table plus
// handshake, back-to-back and reset-during-run sequences.
module tb_nibble_serial_addsub;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        logic             z;
    } vec_t;

    vec_t vecs[8];

    int errors = 0;
    int checks = 0;
    int t0     = 0;

    // Values the outputs must hold until the next done
    logic [WIDTH-1:0] hold_res = '0;
    logic             hold_c   = 1'b0;
    logic             hold_v   = 1'b0;
    logic             hold_z   = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Called at a negedge: present the operation so it is sampled at the next
    // rising edge (cycle 0), then scramble the inputs.
    task automatic start_op(input vec_t v);
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        sub   = v.sub;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom_range(0, 65535));
        b     = WIDTH'($urandom_range(0, 65535));
        sub   = 1'($urandom_range(0, 1));
    endtask

    // Cycles 1..4: busy, no done, outputs held; optional ignored start.
    task automatic run_phase(input bit noise);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("busy_c%0d", k), busy, 1'b1);
            chk($sformatf("done_c%0d", k), done, 1'b0);
            chk($sformatf("hold_res_c%0d", k), result, hold_res);
            chk($sformatf("hold_flags_c%0d", k), {overflow, carry, zero}, {hold_v, hold_c, hold_z});
            if (noise && (k == 2 || k == 3)) begin
                start = 1'b1;
                a     = 16'hDEAD;
                b     = 16'hBEEF;
                sub   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Cycle 5: done pulse with result and flags
    task automatic done_phase(input vec_t v, input string tag);
        chk({tag, ".latency"}, cyc - t0, 5);
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".result"}, result, v.res);
        chk({tag, ".carry"}, carry, v.c);
        chk({tag, ".overflow"}, overflow, v.v);
        chk({tag, ".zero"}, zero, v.z);
        hold_res = v.res;
        hold_c   = v.c;
        hold_v   = v.v;
        hold_z   = v.z;
    endtask

    initial begin
        vec_t vx;
        vec_t vy;
        int   t_first;
        bit   saw_done;

        //             a         b         sub   result    c     v     z
        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.result", result, 16'h0000);
        chk("rst.flags", {overflow, carry, zero}, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        // Vector table; odd entries are followed by an idle cycle, even
        // entries run straight into the next start from DONE.
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i]);
            run_phase(1'b0);
            done_phase(vecs[i], $sformatf("vec%0d", i));
            if (i % 2 == 1) begin
                @(negedge clk);
                chk($sformatf("vec%0d.idle_done", i), done, 1'b0);
                chk($sformatf("vec%0d.idle_busy", i), busy, 1'b0);
                chk($sformatf("vec%0d.idle_hold", i), result, hold_res);
            end
        end

        // Start re-asserted during RUN is ignored
        @(negedge clk);
        start_op(vecs[0]);
        run_phase(1'b1);
        done_phase(vecs[0], "ignore_start");

        // Back-to-back: second start in the done cycle, second done at cycle 10
        @(negedge clk);
        vx = vecs[2];
        vy = vecs[4];
        start_op(vx);
        t_first = t0;
        run_phase(1'b0);
        done_phase(vx, "b2b_first");
        start_op(vy);
        run_phase(1'b0);
        done_phase(vy, "b2b_second");
        chk("b2b.total_latency", cyc - t_first, 10);

        // Reset asserted in cycle 2 of a RUN
        @(negedge clk);
        start_op(vecs[6]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.done", done, 1'b0);
        chk("midrst.result", result, 16'h0000);
        chk("midrst.flags", {overflow, carry, zero}, 3'b000);
        hold_res = '0;
        hold_c   = 1'b0;
        hold_v   = 1'b0;
        hold_z   = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("midrst.no_done", saw_done, 1'b0);
        start_op(vecs[3]);
        run_phase(1'b0);
        done_phase(vecs[3], "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
